// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a 2-entry skid buffer so in_ready is a pure register decode.
// Optional performance counters (stall_cnt, bubble_cnt) are built when PERF_CNT_EN is defined.
module pipe_skid_stage #(
`ifdef PERF_CNT_EN
    parameter int unsigned CNT_W = 16,
`endif
    parameter int unsigned DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Once out_valid is raised it stays high with stable out_data until out_fire.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE_VAL;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else if (flush) begin
            // An in_fire in this cycle is dropped; an out_fire already counted as delivered.
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q  <= in_data;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q  <= in_data;
                        state_q <= FULL;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Counters saturate and survive flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!out_valid && (bubble_q != {CNT_W{1'b1}})) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a queue scoreboard on the output.
module tb_pipe_skid_stage;

    localparam int unsigned DW = 16;
    localparam logic [DW-1:0] BUBBLE = 16'hB0B0;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef PERF_CNT_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   bubble_cnt;
    logic          s_in_valid;
    logic          s_in_ready;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_stall_cnt;
    logic [1:0]    s_bubble_cnt;
    logic [1:0]    s_dbg_state;

    pipe_skid_stage #(.CNT_W(16), .DATA_W(DW), .BUBBLE_VAL(BUBBLE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .dbg_state(dbg_state)
    );

    pipe_skid_stage #(.CNT_W(2), .DATA_W(DW), .BUBBLE_VAL(BUBBLE)) dut_sat (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(16'h0042),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt), .dbg_state(s_dbg_state)
    );
`else
    pipe_skid_stage #(.DATA_W(DW), .BUBBLE_VAL(BUBBLE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dbg_state(dbg_state)
    );
`endif

    // Scoreboard: inputs are stable at the falling edge, so these are the handshakes of the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (!out_valid) begin
                checks++;
                if (out_data !== BUBBLE) begin
                    errors++;
                    $display("FAIL sb_bubble got %h exp %h", out_data, BUBBLE);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got %h exp nothing", out_data);
                end else begin
                    if (out_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL sb_data got %h exp %h", out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        #1;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== BUBBLE) begin
            errors++;
            $display("FAIL reset_values got rdy=%b vld=%b data=%h exp 1 0 %h", in_ready, out_valid, out_data, BUBBLE);
        end
        checks++;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0001;
        step();
        in_data = 16'h0002;
        step();
        in_valid = 1'b0;
        chk("reset_fill_state", {14'd0, dbg_state}, 16'd2);
        chk("reset_fill_ready", {15'd0, in_ready}, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== BUBBLE || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_async got rdy=%b vld=%b data=%h st=%0d exp 1 0 %h 0", in_ready, out_valid, out_data, dbg_state, BUBBLE);
        end
        rst = 1'b0;
        exp_q.delete();
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i >= 2) begin
                chk("stream_valid", {15'd0, out_valid}, 16'd1);
                chk("stream_data", out_data, DW'(i - 1));
            end
            chk("stream_ready", {15'd0, in_ready}, 16'd1);
            if (i <= 8) begin
                in_valid = 1'b1;
                in_data = DW'(i);
            end else begin
                in_valid = 1'b0;
            end
        end
        step();
        chk("stream_drained", {15'd0, out_valid}, 16'd0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h000A;
        step();
        chk("bp_ready_one", {15'd0, in_ready}, 16'd1);
        chk("bp_data_a0", out_data, 16'h000A);
        in_data = 16'h000B;
        step();
        chk("bp_ready_full", {15'd0, in_ready}, 16'd0);
        chk("bp_data_a1", out_data, 16'h000A);
        in_data = 16'h000C;
        step();
        chk("bp_ready_held", {15'd0, in_ready}, 16'd0);
        chk("bp_data_a2", out_data, 16'h000A);
        chk("bp_valid_held", {15'd0, out_valid}, 16'd1);
        out_ready = 1'b1;
        step();
        chk("bp_data_b", out_data, 16'h000B);
        chk("bp_ready_back", {15'd0, in_ready}, 16'd1);
        step();
        chk("bp_data_c", out_data, 16'h000C);
        in_valid = 1'b0;
        step();
        chk("bp_drained", {15'd0, out_valid}, 16'd0);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0011;
        step();
        in_data = 16'h0012;
        step();
        in_data = 16'h000D;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_valid", {15'd0, out_valid}, 16'd0);
        chk("flush_full_data", out_data, BUBBLE);
        chk("flush_full_ready", {15'd0, in_ready}, 16'd1);
        out_ready = 1'b1;
        step();
        chk("flush_no_d", {15'd0, out_valid}, 16'd0);
        // ONE state, delivering 0x21 in the flush cycle while 0xE arrives and is discarded.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0021;
        step();
        out_ready = 1'b1;
        in_data = 16'h000E;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_one_valid", {15'd0, out_valid}, 16'd0);
        chk("flush_one_state", {14'd0, dbg_state}, 16'd0);
        step();
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0005;
        step();
        in_data = 16'h0006;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("simul_data", out_data, 16'h0006);
        chk("simul_state", {14'd0, dbg_state}, 16'd1);
        step();
        chk("simul_drained", {15'd0, out_valid}, 16'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = DW'($urandom_range(0, 16'hFFFF));
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 40) == 0);
            step();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain got %0d pending exp 0", exp_q.size());
        end
    endtask

`ifdef PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        s_in_valid = 1'b0;
        s_out_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("perf_reset_stall", stall_cnt, 16'd0);
        chk("perf_reset_bubble", bubble_cnt, 16'd0);
        repeat (3) step();
        in_valid = 1'b1;
        in_data = 16'h0077;
        s_in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        s_in_valid = 1'b0;
        repeat (3) step();
        chk("perf_stall", stall_cnt, 16'd3);
        chk("perf_bubble", bubble_cnt, 16'd4);
        repeat (2) step();
        chk("perf_sat_stall", {14'd0, s_stall_cnt}, 16'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf_flush_stall", stall_cnt, 16'd6);
        chk("perf_flush_bubble", bubble_cnt, 16'd4);
        step();
        chk("perf_after_bubble", bubble_cnt, 16'd5);
        s_out_ready = 1'b1;
        out_ready = 1'b1;
        step();
    endtask
`endif

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
`ifdef PERF_CNT_EN
        s_in_valid = 1'b0;
        s_out_ready = 1'b0;
`endif
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_random();
`ifdef PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline stage register with a valid/ready handshake. It generalises the fetch/decode latch: any stage boundary (IF/ID, ID/EX, ...) instantiates it with its own payload width.
A 2-entry skid buffer lets in_ready be a pure register output, so the backpressure path out_ready -> in_ready carries no combinational logic.
A synchronous flush squashes both entries for branch and exception redirects.

Parameters:
DATA_W, 64, payload width in bits (e.g. {PC+4, instruction}).
BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0 (NOP encoding).
CNT_W, 16, width of the performance counters (used only with PERF_CNT_EN).

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous squash of all held entries.
in_valid  in  1  upstream presents in_data.
in_ready  out  1  stage can accept. Registered, no combinational input dependency.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  main entry valid.
out_ready  in  1  downstream accepts.
out_data  out  DATA_W  main entry payload, or BUBBLE_VAL when invalid.
stall_cnt  out  CNT_W  only with PERF_CNT_EN.
bubble_cnt  out  CNT_W  only with PERF_CNT_EN.

Behaviour:
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives the output) and skid register. Encoded state: EMPTY, ONE (main valid), FULL (main and skid valid).
- Reset values: state=EMPTY; in_ready=1; out_valid=0; out_data=BUBBLE_VAL; both data registers=BUBBLE_VAL; counters=0.
- in_ready = (state != FULL), decoded from registered state only.
- out_valid = (state != EMPTY). out_data = main when valid, else BUBBLE_VAL.
- Transitions, evaluated when flush=0:
  - EMPTY: in_fire -> ONE, main<=in_data. Otherwise stay.
  - ONE: in_fire & out_fire -> ONE, main<=in_data. in_fire only -> FULL, skid<=in_data. out_fire only -> EMPTY. Neither -> hold.
  - FULL: in_ready=0 so in_fire is impossible. out_fire -> ONE, main<=skid. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid. Throughput: 1 item/cycle while out_ready=1.
- Ordering: strict FIFO. Skid data always leaves after main data.
- Payload integrity: data is never dropped or duplicated except by flush.
- Flush (highest priority after rst): next state=EMPTY and both entries invalidated.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered.
  - in_ready=1 on the cycle after flush.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). No entry survives.
- Hold behaviour: with out_ready=0 in ONE or FULL, out_data and out_valid stay stable (no retraction).

Optional Feature:
PERF_CNT_EN.
- Defined: stall_cnt increments each cycle with out_valid=1 & out_ready=0. bubble_cnt increments each cycle with out_valid=0.
  - Both saturate at all-ones.
  - Both are cleared only by rst; flush does not clear them.
- Not defined: stall_cnt and bubble_cnt ports and their logic are absent. Datapath behaviour is identical.

Test Plan:
1. Reset: assert rst mid-cycle with state FULL -> out_valid=0, out_data=BUBBLE_VAL, in_ready=1 immediately, without waiting for a clock edge.
2. Streaming: out_ready=1; in_valid=1 with data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles, one cycle later; in_ready stays 1.
3. Backpressure: stream 0xA, 0xB, 0xC with out_ready=0 -> 0xA and 0xB are accepted, then in_ready=0 and 0xC is held upstream. Releasing out_ready -> outputs in order 0xA, 0xB, 0xC; in_ready returns to 1 the cycle after the first out_fire.
4. Flush while FULL, with in_valid=1 (data 0xD) -> next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1; 0xD never appears at the output.
5. Simultaneous in_fire and out_fire in ONE (main=0x5, in=0x6) -> next cycle main=0x6, state stays ONE, 0x5 is delivered exactly once.
6. PERF_CNT_EN: 3 cycles valid with out_ready=0 and 4 idle cycles -> stall_cnt=3, bubble_cnt=4. With CNT_W=2 and 5 stall cycles -> stall_cnt saturates at 3.
